// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one word fetch in flight, buffers returned
// instructions and hands {instr, pc} to decode. Redirects flush the buffer and drop a stale response.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [1:0]  fetch_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state;
    logic [31:0]       pc;
    logic [31:0]       req_pc;
    logic [31:0]       redirect_target;
    logic [31:0]       buf_instr [DEPTH];
    logic [31:0]       buf_pc    [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next_cap;
    logic              rsp_live;
    logic              push;
    logic              pop;
    logic              req_fire;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the responder may not withdraw ready mid-cycle, and the fetch stage holds
    // imem_req_valid/imem_addr stable until accepted unless a redirect or response drops it.
    assign redirect_target = redirect_pc & ~32'd3;
    assign rsp_live        = (state != S_IDLE) && imem_rsp_valid;
    assign push            = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign id_valid        = (count != '0) && !redirect_valid;
    assign pop             = id_valid && id_ready;
    assign count_next_cap  = count + CNT_W'(push) - CNT_W'(pop);

    // A new request is issued only when its eventual response is guaranteed a free slot.
    assign imem_req_valid = rst_n && !redirect_valid
                          && ((state == S_IDLE) || rsp_live)
                          && (count_next_cap < CNT_W'(DEPTH));
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign imem_addr      = pc;

    assign id_instr    = (count != '0) ? buf_instr[rd_ptr] : NOP_INSTR;
    assign id_pc       = (count != '0) ? buf_pc[rd_ptr]    : 32'h0;
    assign fetch_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_target;
            if (rsp_live) begin
                state <= S_IDLE;
            end else if (state == S_WAIT) begin
                state <= S_DROP;
            end
        end else if (req_fire) begin
            pc     <= pc + 32'd4;
            req_pc <= pc;
            state  <= S_WAIT;
        end else if (rsp_live) begin
            state <= S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count_next_cap;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rsp_data;
            buf_pc[wr_ptr]    <= req_pc;
        end
    end

`ifndef SYNTHESIS
    rsp_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && state == S_IDLE));
    push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count == CNT_W'(DEPTH)));
`endif

endmodule
